// File: rtl/truth_table_capture.sv
// truth_table_capture: steps a 3-input logic stage through every input
// pattern, captures its output into a truth-table word and scores it
// against EXPECTED (pass flag, error count, first mismatching index).
// Optional feature macro: TT_STICKY_FAIL_EN adds a fail_sticky output
// that latches any failing run until rst_n.
module truth_table_capture #(
  parameter int unsigned               N_IN     = 3,
  parameter int                        SETTLE   = 2,
  parameter logic [(2**N_IN)-1:0]      EXPECTED = 8'hF7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   dut_out,
  output logic [N_IN-1:0]        pattern,
  output logic                   busy,
  output logic                   done,
  output logic [(2**N_IN)-1:0]   table_out,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic [N_IN-1:0]        mismatch_idx
`ifdef TT_STICKY_FAIL_EN
  , output logic                 fail_sticky
`endif
);

  localparam int NPAT    = 2**N_IN;
  // A hold time of zero cycles makes no sense; clamp to one.
  localparam int SET_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CW      = (SET_EFF > 1) ? $clog2(SET_EFF) : 1;
  localparam logic [CW-1:0]   RELOAD = CW'(SET_EFF - 1);
  localparam logic [N_IN-1:0] LAST   = N_IN'(NPAT - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_e;

  state_e              state_q, state_d;
  logic [N_IN-1:0]     idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NPAT-1:0]     table_q, table_d;
  logic                pass_q, pass_d;
  logic [N_IN:0]       err_q, err_d;
  logic [N_IN-1:0]     midx_q, midx_d;
  logic                sticky_q, sticky_d;

  // Table as it will look after the current sample is written.
  logic [NPAT-1:0]     final_tbl;
  logic [NPAT-1:0]     diff;
  logic                sc_pass;
  logic [N_IN:0]       sc_err;
  logic [N_IN-1:0]     sc_idx;

  // Merge the live sample into the table so scoring sees the final bit.
  always_comb begin
    final_tbl         = table_q;
    final_tbl[idx_q]  = dut_out;
  end

  // Score the merged table: popcount of differences and lowest differing bit.
  always_comb begin
    diff   = final_tbl ^ EXPECTED;
    sc_err = '0;
    sc_idx = '0;
    for (int k = NPAT - 1; k >= 0; k--) begin
      if (diff[k]) begin
        sc_err = sc_err + (N_IN+1)'(1);
        sc_idx = N_IN'(k);
      end
    end
    sc_pass = (diff == '0);
  end

  // Next-state logic for the IDLE -> DRIVE -> DONE sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    table_d  = table_q;
    pass_d   = pass_q;
    err_d    = err_q;
    midx_d   = midx_q;
    sticky_d = sticky_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          table_d = '0;
          pass_d  = 1'b0;
          err_d   = '0;
          midx_d  = '0;
          idx_d   = '0;
          cnt_d   = RELOAD;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          table_d = final_tbl;
          if (idx_q == LAST) begin
            // Results are registered on DONE entry so they are valid with done.
            pass_d  = sc_pass;
            err_d   = sc_err;
            midx_d  = sc_idx;
            if (!sc_pass) sticky_d = 1'b1;
            state_d = DONE;
          end else begin
            idx_d = idx_q + N_IN'(1);
            cnt_d = RELOAD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any run and clears results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      table_q  <= '0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      midx_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      table_q  <= table_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      midx_q   <= midx_d;
      sticky_q <= sticky_d;
    end
  end

  assign busy         = (state_q == DRIVE);
  assign done         = (state_q == DONE);
  assign pattern      = busy ? idx_q : '0;
  assign table_out    = table_q;
  assign pass         = pass_q;
  assign err_count    = err_q;
  assign mismatch_idx = midx_q;

`ifdef TT_STICKY_FAIL_EN
  assign fail_sticky  = sticky_q;
`else
  // Without the sticky output the flag has no observer.
  logic unused_sticky;
  assign unused_sticky = sticky_q;
`endif

endmodule

// File: doc/truth_table_capture.md
Name: truth_table_capture

Overview:
- Sequencing stage wrapped around the 3-input combinational logic stage.
- Upstream: drives the {A,B,C} input pattern through all 2**N_IN combinations.
- Downstream: samples the stage's single-bit output per pattern and assembles a truth-table word.
- Compares the captured table against an expected word and reports pass/fail, error count and first mismatching index.

Parameters:
N_IN, 3, number of driven inputs; pattern MSB maps to A, LSB to C
SETTLE, 2, cycles each pattern is held before sampling; values below 1 are treated as 1
EXPECTED, 8'hF7, expected truth table (width 2**N_IN); bit k = expected output for pattern k

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  run request, sampled in IDLE only
dut_out  in  1  output of the logic stage under capture
pattern  out  N_IN  input combination driven to the logic stage
busy  out  1  high while a run is in progress
done  out  1  one-cycle pulse when a run completes
table_out  out  2**N_IN  captured truth table; bit k = dut_out sampled for pattern k
pass  out  1  table_out == EXPECTED, valid from done
err_count  out  N_IN+1  popcount(table_out ^ EXPECTED)
mismatch_idx  out  N_IN  lowest k where bit k differs; 0 when pass

Behaviour:
- Reset: one clock, asynchronous active-low reset (clk, rst_n). Reset is asserted asynchronously and released synchronously to clk.
- Reset values: all outputs 0 and state IDLE. Reset mid-run aborts immediately and discards the partial table.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - pattern=0, busy=0.
  - start=1 at edge t0 clears table_out, pass, err_count and mismatch_idx.
  - Same edge: idx=0, settle counter=SETTLE-1, next state DRIVE.
- DRIVE:
  - busy=1, pattern=idx.
  - When counter>0: counter decrements each edge.
  - When counter==0: the edge writes dut_out into table_out[idx].
    - If idx==2**N_IN-1: next state DONE.
    - Otherwise: idx+1 and counter reloads SETTLE-1.
  - Sample edge for pattern k is t0+SETTLE*(k+1). Each pattern is held exactly SETTLE cycles.
- DONE (one cycle):
  - done=1, busy=0, pattern=0.
  - pass, err_count and mismatch_idx are valid this cycle. They are computed combinationally from the final table and registered on DONE entry.
  - Next edge returns to IDLE.
  - table_out, pass, err_count and mismatch_idx hold until the next accepted start or reset.
- start handling:
  - start while busy or in DONE is ignored; no queuing.
  - start held high continuously restarts from IDLE after each DONE, giving a back-to-back run every 2**N_IN*SETTLE+2 cycles.
- Timing assumption: dut_out is combinational from pattern in the same clock domain. No synchronizer. SETTLE covers logic settling.
- Latency: start edge to done high = 2**N_IN*SETTLE cycles (16 with defaults).

Optional Feature:
- Macro TT_STICKY_FAIL_EN.
- Defined:
  - Adds output fail_sticky (1 bit, reset 0).
  - fail_sticky sets in the DONE cycle of any run with pass=0.
  - Cleared only by rst_n; start does not clear it.
- Undefined:
  - Port and logic absent.
  - Failure is visible only through pass of the most recent run.

Test Plan:
1. Defaults, dut_out=~(~A&B&C), start pulse → done 16 cycles after the start edge; table_out=8'hF7, pass=1, err_count=0, mismatch_idx=0; pattern steps 0..7, each held 2 cycles.
2. dut_out stuck at 1 → table_out=8'hFF, pass=0, err_count=1, mismatch_idx=3; fail_sticky=1 if TT_STICKY_FAIL_EN.
3. dut_out stuck at 0 → table_out=8'h00, pass=0, err_count=7, mismatch_idx=0.
4. start re-pulsed at cycles 3 and 9 of a run → ignored; single done at cycle 16; correct table.
5. rst_n low while pattern=5 → all outputs 0 asynchronously, pattern=0. After release, new start with a correct model gives table_out=8'hF7 and pass=1; fail_sticky stays 0.
6. SETTLE=1 with correct model, start held high → done every 10 cycles; each run table_out=8'hF7, pass=1.
